// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and access-size helpers for the load/store unit.
package lsu_pkg;

    // RV32I funct3 size codes (loads and stores share the low two bits)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // One memory word's worth of steered data and its byte enables
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } lane_word_t;

    // Access size in bytes for a funct3 code
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsupported size codes for the given direction
    function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 > F3_W;
        end
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output lane_word_t  lo,
    output lane_word_t  hi,
    output logic [31:0] load_data
);

    logic [7:0]  size_mask;
    logic [7:0]  be_win;
    logic [31:0] data_mask;
    logic [63:0] st_win;
    logic [31:0] raw;

    // Shift the store across an 8-byte window; low half goes out first, high half second
    always_comb begin
        case (funct3[1:0])
            2'b00:   begin size_mask = 8'h01; data_mask = 32'h0000_00FF; end
            2'b01:   begin size_mask = 8'h03; data_mask = 32'h0000_FFFF; end
            default: begin size_mask = 8'h0F; data_mask = 32'hFFFF_FFFF; end
        endcase
        be_win = size_mask << offset;
        st_win = {32'd0, wdata & data_mask} << {offset, 3'b000};
        lo     = '{data: st_win[31:0],  be: be_win[3:0]};
        hi     = '{data: st_win[63:32], be: be_win[7:4]};
    end

    // Realign the two captured words down to lane 0 and extend to 32 bits
    always_comb begin
        raw = 32'({rdata_hi, rdata_lo} >> {offset, 3'b000});
        case (funct3)
            F3_B:    load_data = {{24{raw[7]}},  raw[7:0]};
            F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   load_data = {24'd0, raw[7:0]};
            F3_HU:   load_data = {16'd0, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: size/fault decode, split misaligned accesses into two word transactions.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    lsu_state_e        state, state_nxt;
    logic              op_we, op_we_nxt;
    logic [2:0]        op_funct3, op_funct3_nxt;
    logic [1:0]        op_offset, op_offset_nxt;
    logic              op_cross, op_cross_nxt;
    lane_word_t        hi_buf, hi_buf_nxt;
    logic [31:0]       lo_rdata, lo_rdata_nxt;

    logic              ready_nxt, done_nxt, fault_nxt, read_nxt, write_nxt;
    logic [31:0]       rdata_nxt, wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [3:0]        be_nxt;

    logic [ADDR_W:0]   end_addr;
    logic              req_fault;
    lane_word_t        lo_lanes, hi_lanes;
    logic [31:0]       load_data;
    logic [2:0]        align_funct3;
    logic [1:0]        align_offset;
    logic [31:0]       align_rdata_lo;
    logic              busy_nxt;

    // Last byte touched by the incoming request, one bit wider so the top address cannot wrap
    assign end_addr  = {1'b0, cpu_addr} + (ADDR_W+1)'(access_size(cpu_funct3)) - (ADDR_W+1)'(1);
    assign req_fault = illegal_funct3(cpu_we, cpu_funct3) || (end_addr >= (ADDR_W+1)'(MEM_BYTES));

    // Steering uses the live request while accepting; extraction uses the latched request while busy
    assign align_funct3   = cpu_ready ? cpu_funct3 : op_funct3;
    assign align_offset   = cpu_ready ? cpu_addr[1:0] : op_offset;
    assign align_rdata_lo = (state == ACC0) ? mem_rdata : lo_rdata;

    lsu_lane_align u_align (
        .funct3    (align_funct3),
        .offset    (align_offset),
        .wdata     (cpu_wdata),
        .rdata_lo  (align_rdata_lo),
        .rdata_hi  (mem_rdata),
        .lo        (lo_lanes),
        .hi        (hi_lanes),
        .load_data (load_data)
    );

    // Next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        op_we_nxt     = op_we;
        op_funct3_nxt = op_funct3;
        op_offset_nxt = op_offset;
        op_cross_nxt  = op_cross;
        hi_buf_nxt    = hi_buf;
        lo_rdata_nxt  = lo_rdata;
        rdata_nxt     = cpu_rdata;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        be_nxt        = mem_be;
        fault_nxt     = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                be_nxt    = '0;
                if (cpu_req) begin
                    if (req_fault) begin
                        state_nxt = DONE;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt     = ACC0;
                        op_we_nxt     = cpu_we;
                        op_funct3_nxt = cpu_funct3;
                        op_offset_nxt = cpu_addr[1:0];
                        op_cross_nxt  = |hi_lanes.be;
                        hi_buf_nxt    = hi_lanes;
                        addr_nxt      = {cpu_addr[ADDR_W-1:2], 2'b00};
                        wdata_nxt     = lo_lanes.data;
                        be_nxt        = lo_lanes.be;
                    end
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    lo_rdata_nxt = mem_rdata;
                    if (op_cross) begin
                        state_nxt = ACC1;
                        addr_nxt  = mem_addr + ADDR_W'(4);
                        wdata_nxt = hi_buf.data;
                        be_nxt    = hi_buf.be;
                    end else begin
                        state_nxt = DONE;
                        be_nxt    = '0;
                        if (!op_we) rdata_nxt = load_data;
                    end
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                    be_nxt    = '0;
                    if (!op_we) rdata_nxt = load_data;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt  = (state_nxt == ACC0) || (state_nxt == ACC1);
        ready_nxt = (state_nxt == IDLE) || (state_nxt == DONE);
        done_nxt  = (state_nxt == DONE);
        read_nxt  = busy_nxt && !op_we_nxt;
        write_nxt = busy_nxt && op_we_nxt;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_funct3 <= '0;
            op_offset <= '0;
            op_cross  <= 1'b0;
            hi_buf    <= '0;
            lo_rdata  <= '0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_fault <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_we     <= op_we_nxt;
            op_funct3 <= op_funct3_nxt;
            op_offset <= op_offset_nxt;
            op_cross  <= op_cross_nxt;
            hi_buf    <= hi_buf_nxt;
            lo_rdata  <= lo_rdata_nxt;
            cpu_ready <= ready_nxt;
            cpu_done  <= done_nxt;
            cpu_fault <= fault_nxt;
            cpu_rdata <= rdata_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_be    <= be_nxt;
            mem_read  <= read_nxt;
            mem_write <= write_nxt;
        end
    end

endmodule
